scan_demux: RTL and testbench

//   Receive end of the 4-digit time-multiplexed display scan bus (scan_data nibble + 2-bit

---
 rtl/scan_demux.sv | 208 ++++++++++++++++++++
 tb/tb_scan_demux.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/scan_demux.sv
// scan_demux: receive end of the 4-digit time-multiplexed display scan bus.
//   Rebuilds four static digit registers from the {scan_bit, scan_data} stream.
//   Each sample must be stable for STABLE_CNT cycles before it is latched.
//   Checks that digits arrive in scan order 0-1-2-3 and counts completed frames.
//
// Optional feature: define SCAN_TIMEOUT_EN to enable stalled-scan detection.
//   With the macro undefined, scan_timeout is tied to 0.
//
// Ports:
//   clk           system clock, rising edge
//   sys_rst       synchronous reset, active-high
//   scan_data[4]  multiplexed digit value
//   scan_bit[2]   digit select 0..3
//   dig0..dig3[4] reconstructed digit values
//   dig_valid[4]  bit d set once digit d latched since reset/timeout
//   frame_done    1-cycle pulse on in-order latch of digit 3
//   seq_err       1-cycle pulse on out-of-order digit
//   frame_cnt[8]  completed-frame count (wraps)
//   scan_timeout  scan stalled
//
// state  | meaning
// S_SYNC | waiting for digit 0 to start a frame
// S_D0   | expecting digit 0 (previous frame just completed)
// S_D1   | expecting digit 1
// S_D2   | expecting digit 2
// S_D3   | expecting digit 3; in-order arrival completes the frame
module scan_demux #(
  parameter int STABLE_CNT = 2,
  parameter int TIMEOUT    = 15,
  parameter int TO_W       = 4
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic [3:0] scan_data,
  input  logic [1:0] scan_bit,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] dig_valid,
  output logic       frame_done,
  output logic       seq_err,
  output logic [7:0] frame_cnt,
  output logic       scan_timeout
);

  localparam int RUN_W = $clog2(STABLE_CNT + 1);

  typedef enum logic [2:0] {S_SYNC, S_D0, S_D1, S_D2, S_D3} state_t;

  state_t          state_q, state_d;
  logic [5:0]      s_q, s_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [3:0][3:0] digs_q, digs_d;
  logic [3:0]      valid_q, valid_d;
  logic [1:0]      last_q, last_d;
  logic            fd_q, fd_d;
  logic            se_q, se_d;
  logic [7:0]      fc_q, fc_d;

  logic            changed, latch, ev;
  logic [1:0]      ev_dig, exp_dig;

`ifdef SCAN_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;
  logic            tmo_q, tmo_d;
  logic            to_fire;
`else
  logic            unused_cfg;
  assign unused_cfg = ^{TIMEOUT, TO_W};
`endif

  always_comb begin
    case (state_q)
      S_D1:    exp_dig = 2'd1;
      S_D2:    exp_dig = 2'd2;
      S_D3:    exp_dig = 2'd3;
      default: exp_dig = 2'd0;
    endcase
  end

  always_comb begin
    s_d     = {scan_bit, scan_data};
    changed = (s_d != s_q);
    run_d   = run_q;
    if (changed)
      run_d = RUN_W'(1);
    else if (run_q != RUN_W'(STABLE_CNT))
      run_d = run_q + 1'b1;
    // Latch once per stable run: on the edge the run count arrives at STABLE_CNT.
    latch   = (run_d == RUN_W'(STABLE_CNT)) && (changed || run_q != RUN_W'(STABLE_CNT));
    ev_dig  = s_d[5:4];

    digs_d  = digs_q;
    valid_d = valid_q;
    last_d  = last_q;
    state_d = state_q;
    fd_d    = 1'b0;
    se_d    = 1'b0;
    ev      = 1'b0;

    if (latch) begin
      digs_d[ev_dig]  = s_d[3:0];
      valid_d[ev_dig] = 1'b1;
      // Same digit as last time is a refresh within one dwell: data only.
      if (ev_dig != last_q) begin
        last_d = ev_dig;
        ev     = 1'b1;
      end
    end

    if (ev) begin
      case (state_q)
        S_SYNC: if (ev_dig == 2'd0) state_d = S_D1;
        default: begin
          if (ev_dig == exp_dig) begin
            case (state_q)
              S_D0:    state_d = S_D1;
              S_D1:    state_d = S_D2;
              S_D2:    state_d = S_D3;
              default: begin
                state_d = S_D0;
                fd_d    = 1'b1;
              end
            endcase
          end else begin
            se_d    = 1'b1;
            state_d = (ev_dig == 2'd0) ? S_D1 : S_SYNC;
          end
        end
      endcase
    end

`ifdef SCAN_TIMEOUT_EN
    to_fire = (to_q == TO_W'(TIMEOUT));
    if (s_d[5:4] != s_q[5:4])
      to_d = '0;
    else if (to_fire)
      to_d = to_q;
    else
      to_d = to_q + 1'b1;
    // to_q is zero only on the edge following a scan_bit change.
    if (to_fire)
      tmo_d = 1'b1;
    else if (to_q == '0)
      tmo_d = 1'b0;
    else
      tmo_d = tmo_q;
    // Timeout takes priority over any event on the same edge; digit data is kept.
    if (to_fire) begin
      state_d = S_SYNC;
      valid_d = '0;
      last_d  = 2'd3;
      fd_d    = 1'b0;
      se_d    = 1'b0;
    end
`endif

    fc_d = fd_d ? fc_q + 8'd1 : fc_q;
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q <= S_SYNC;
      s_q     <= '0;
      run_q   <= '0;
      digs_q  <= '0;
      valid_q <= '0;
      last_q  <= 2'd3;
      fd_q    <= 1'b0;
      se_q    <= 1'b0;
      fc_q    <= '0;
`ifdef SCAN_TIMEOUT_EN
      to_q    <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      run_q   <= run_d;
      digs_q  <= digs_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      fd_q    <= fd_d;
      se_q    <= se_d;
      fc_q    <= fc_d;
`ifdef SCAN_TIMEOUT_EN
      to_q    <= to_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign dig0       = digs_q[0];
  assign dig1       = digs_q[1];
  assign dig2       = digs_q[2];
  assign dig3       = digs_q[3];
  assign dig_valid  = valid_q;
  assign frame_done = fd_q;
  assign seq_err    = se_q;
  assign frame_cnt  = fc_q;
`ifdef SCAN_TIMEOUT_EN
  assign scan_timeout = tmo_q;
`else
  assign scan_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_scan_demux.sv
// Testbench for scan_demux (STABLE_CNT=2, TIMEOUT=15).
module tb_scan_demux;

  logic       clk;
  logic       sys_rst;
  logic [3:0] scan_data;
  logic [1:0] scan_bit;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic [3:0] dig_valid;
  logic       frame_done, seq_err, scan_timeout;
  logic [7:0] frame_cnt;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;
  int se_cnt = 0;

  scan_demux #(.STABLE_CNT(2), .TIMEOUT(15), .TO_W(4)) dut (
    .clk(clk), .sys_rst(sys_rst), .scan_data(scan_data), .scan_bit(scan_bit),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig_valid(dig_valid),
    .frame_done(frame_done), .seq_err(seq_err), .frame_cnt(frame_cnt),
    .scan_timeout(scan_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (seq_err === 1'b1)    se_cnt++;
  end

  typedef struct {
    logic [1:0]  b;
    logic [3:0]  d;
    int          n;
    logic [15:0] digs;
    logic [3:0]  val;
    int          fd;
    int          se;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic [1:0] b, input logic [3:0] d, input int n);
    scan_bit  = b;
    scan_data = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_digs"},  {16'h0, dig3, dig2, dig1, dig0}, 32'h0);
    chk({tag, "_valid"}, {28'h0, dig_valid}, 32'h0);
    chk({tag, "_fdone"}, {31'h0, frame_done}, 32'h0);
    chk({tag, "_serr"},  {31'h0, seq_err}, 32'h0);
    chk({tag, "_fcnt"},  {24'h0, frame_cnt}, 32'h0);
    chk({tag, "_tmo"},   {31'h0, scan_timeout}, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bfd, bse;
    //        bit   data  n  {d3,d2,d1,d0} valid  fd se
    vt[0]  = '{2'd0, 4'h5, 5, 16'h0005, 4'b0001, 0, 0};
    vt[1]  = '{2'd1, 4'h6, 5, 16'h0065, 4'b0011, 0, 0};
    vt[2]  = '{2'd2, 4'h7, 5, 16'h0765, 4'b0111, 0, 0};
    vt[3]  = '{2'd3, 4'h8, 5, 16'h8765, 4'b1111, 1, 0};
    vt[4]  = '{2'd0, 4'h1, 5, 16'h8761, 4'b1111, 1, 0};
    vt[5]  = '{2'd1, 4'h2, 5, 16'h8721, 4'b1111, 1, 0};
    vt[6]  = '{2'd3, 4'h3, 5, 16'h3721, 4'b1111, 1, 1};
    vt[7]  = '{2'd0, 4'h4, 5, 16'h3724, 4'b1111, 1, 1};
    vt[8]  = '{2'd1, 4'h5, 5, 16'h3754, 4'b1111, 1, 1};
    vt[9]  = '{2'd2, 4'h6, 5, 16'h3654, 4'b1111, 1, 1};
    vt[10] = '{2'd3, 4'h7, 5, 16'h7654, 4'b1111, 2, 1};
    vt[11] = '{2'd0, 4'h0, 5, 16'h7650, 4'b1111, 2, 1};
    vt[12] = '{2'd1, 4'h6, 3, 16'h7660, 4'b1111, 2, 1};
    vt[13] = '{2'd2, 4'hA, 1, 16'h7660, 4'b1111, 2, 1};
    vt[14] = '{2'd1, 4'h6, 3, 16'h7660, 4'b1111, 2, 1};
    vt[15] = '{2'd1, 4'h9, 3, 16'h7690, 4'b1111, 2, 1};
    vt[16] = '{2'd2, 4'h2, 5, 16'h7290, 4'b1111, 2, 1};
    vt[17] = '{2'd3, 4'h3, 5, 16'h3290, 4'b1111, 3, 1};

    sys_rst   = 1'b1;
    scan_bit  = 2'd0;
    scan_data = 4'h0;
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    sys_rst = 1'b0;

    // Basic frame, out-of-order recovery, glitch and refresh.
    for (int i = 0; i < 18; i++) begin
      apply(vt[i].b, vt[i].d, vt[i].n);
      chk($sformatf("v%0d_digs", i), {16'h0, dig3, dig2, dig1, dig0}, {16'h0, vt[i].digs});
      chk($sformatf("v%0d_valid", i), {28'h0, dig_valid}, {28'h0, vt[i].val});
      chk($sformatf("v%0d_fdone", i), fd_cnt, vt[i].fd);
      chk($sformatf("v%0d_serr", i), se_cnt, vt[i].se);
      chk($sformatf("v%0d_fcnt", i), {24'h0, frame_cnt}, vt[i].fd);
    end

    // 300 in-order frames: frame count wraps.
    sys_rst = 1'b1;
    @(negedge clk);
    chk_reset("rst1");
    sys_rst = 1'b0;
    bfd = fd_cnt;
    bse = se_cnt;
    for (int f = 0; f < 300; f++) begin
      for (int k = 0; k < 4; k++) begin
        logic [31:0] v;
        v = f + k;
        apply(2'(k), v[3:0], 3);
      end
      if (f == 254) chk("wrap_255", {24'h0, frame_cnt}, 32'd255);
      if (f == 255) chk("wrap_0", {24'h0, frame_cnt}, 32'd0);
    end
    chk("many_fdone", fd_cnt - bfd, 300);
    chk("many_serr", se_cnt - bse, 0);
    chk("many_fcnt", {24'h0, frame_cnt}, 32'd44);
    chk("many_digs", {16'h0, dig3, dig2, dig1, dig0}, 32'hEDCB);

    // Reset mid-frame, then finish the frame: no pulses.
    apply(2'd0, 4'h1, 5);
    apply(2'd1, 4'h2, 5);
    sys_rst = 1'b1;
    @(negedge clk);
    chk_reset("rst2");
    sys_rst = 1'b0;
    bfd = fd_cnt;
    bse = se_cnt;
    apply(2'd2, 4'h3, 5);
    apply(2'd3, 4'h4, 5);
    chk("midrst_fdone", fd_cnt - bfd, 0);
    chk("midrst_serr", se_cnt - bse, 0);
    chk("midrst_valid", {28'h0, dig_valid}, 32'hC);
    chk("midrst_digs", {16'h0, dig3, dig2, dig1, dig0}, 32'h4300);
    chk("midrst_fcnt", {24'h0, frame_cnt}, 32'd0);

    // Stalled scan, then resume.
    bfd = fd_cnt;
    bse = se_cnt;
    apply(2'd0, 4'h1, 5);
    apply(2'd1, 4'h2, 12);
    chk("stall12_tmo", {31'h0, scan_timeout}, 32'd0);
    apply(2'd1, 4'h2, 8);
`ifdef SCAN_TIMEOUT_EN
    chk("stall20_tmo", {31'h0, scan_timeout}, 32'd1);
    chk("stall20_valid", {28'h0, dig_valid}, 32'h0);
`else
    chk("stall20_tmo", {31'h0, scan_timeout}, 32'd0);
    chk("stall20_valid", {28'h0, dig_valid}, 32'hF);
`endif
    chk("stall20_digs", {16'h0, dig3, dig2, dig1, dig0}, 32'h4321);
    apply(2'd0, 4'h5, 5);
    chk("resume_tmo", {31'h0, scan_timeout}, 32'd0);
    apply(2'd1, 4'h6, 5);
    apply(2'd2, 4'h7, 5);
    apply(2'd3, 4'h8, 5);
    chk("resume_fdone", fd_cnt - bfd, 1);
`ifdef SCAN_TIMEOUT_EN
    chk("resume_serr", se_cnt - bse, 0);
`else
    chk("resume_serr", se_cnt - bse, 1);
`endif
    chk("resume_digs", {16'h0, dig3, dig2, dig1, dig0}, 32'h8765);
    chk("resume_valid", {28'h0, dig_valid}, 32'hF);
    chk("resume_fcnt", {24'h0, frame_cnt}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
